frame_draw_scheduler: RTL and testbench
=======================================

FRAME_DRAW_SCHEDULER -- requirements
Module: frame_draw_scheduler

Interface
REQ-001 clock  input  1  system clock; all state changes on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 frame_tick  input  1  one-cycle frame-start pulse.
REQ-004 game_over  input  1  level; freezes the scene when high.
REQ-005 player_x  input  8  player sprite top-left column.
REQ-006 player_y  input  7  player sprite top-left row.
REQ-007 obstacle_x  input  8  obstacle sprite top-left column.
REQ-008 obstacle_y  input  7  obstacle sprite top-left row.
REQ-009 x  output  8  pixel column to VGA adapter.
REQ-010 y  output  7  pixel row to VGA adapter.
REQ-011 colour  output  3  pixel colour.
REQ-012 plot  output  1  VGA write enable for x/y/colour.
REQ-013 pos_update  output  1  one-cycle pulse; the datapath advances positions.
REQ-014 busy  output  1  frame sequence in progress.
REQ-015 frame_done  output  1  one-cycle pulse at end of sequence.
REQ-016 overrun  output  1  sticky; a frame_tick arrived while busy.

Function
REQ-017 The block SHALL use these states: IDLE, ERASE_P, ERASE_O, UPDATE, LATCH, DRAW_P, DRAW_O, DONE.
REQ-018 All outputs SHALL be registered; "cycle En" means n clock edges after the edge that sampled frame_tick in IDLE.
REQ-019 Sprites SHALL be 8x8, scanned by a 6-bit counter 0..63 in row-major order: col = cnt[2:0], row = cnt[5:3]; one pixel is output per cycle.
REQ-020 The pixel address SHALL be x = base_x + col and y = base_y + row, computed at 9/8-bit width.
REQ-021 A pixel with computed x > 159 or y > 119 SHALL have plot forced low; its cycle is still consumed, and there is no wrap-around.
REQ-022 Full frame timing SHALL be:
- E1..E64: ERASE_P, old player position, colour 000.
- E65..E128: ERASE_O, old obstacle position, colour 000.
- E129: UPDATE, pos_update=1.
- E130: LATCH, captures all four position inputs as the "old" set.
- E131..E194: DRAW_P, colour 100.
- E195..E258: DRAW_O, colour 001.
- E259: DONE, frame_done=1.
REQ-023 busy SHALL be high for E1..E259 and low again from E260.
REQ-024 plot SHALL be low in IDLE, UPDATE, LATCH and DONE.
REQ-025 For the first frame after reset (valid flag clear), the erase states SHALL be skipped: E1 UPDATE, E2 LATCH, E3..E66 DRAW_P, E67..E130 DRAW_O, E131 DONE; the valid flag sets at LATCH.
REQ-026 If game_over is high when frame_tick is sampled in IDLE, the tick SHALL be ignored: the block stays in IDLE, with no pulse and no plot.
REQ-027 A frame_tick seen while busy SHALL be dropped and SHALL set overrun; the sequence in progress is unaffected.
REQ-028 A frame_tick coincident with DONE SHALL be treated as busy (overrun set, tick dropped).
REQ-029 Position inputs SHALL only be sampled at LATCH; changes at other times have no effect on the current sequence.

Reset
REQ-030 On reset the block SHALL go to IDLE with: plot=0, pos_update=0, busy=0, frame_done=0, overrun=0, x=0, y=0, colour=000, counter=0, valid flag clear, latched positions 0.
REQ-031 Reset mid-sequence SHALL abort immediately; the next frame is treated as a first frame (no erase).

Verification
REQ-032 Reset, then pulse frame_tick with player (20,60) and obstacle (150,111) -> pos_update at E1, player pixels (20..27, 60..67) with colour 100 at E3..E66, frame_done at E131.
REQ-033 Second tick, player input now (20,58) -> E1..E64 erase (20,60) block in 000, pos_update at E129, redraw at (20,58) during E131..E194, frame_done at E259.
REQ-034 obstacle_x=156, y=116 -> only cols 156..159 and rows 116..119 plotted (16 plot cycles per sprite pass), and DRAW_O still lasts 64 cycles.
REQ-035 frame_tick again at E100 -> overrun=1 and sticky, frame_done still at E259, and no second sequence starts.
REQ-036 game_over=1 with a tick in IDLE -> busy, plot and pos_update all stay 0.
REQ-037 reset at E70 -> all outputs at reset values next cycle; the following tick produces the first-frame timing (frame_done at E131).

Source files
------------

// File: rtl/frame_draw_scheduler.sv
// Frame draw scheduler: for each accepted frame tick it erases both sprites at
// their old positions, pulses a position update, latches the new positions,
// draws both sprites and then reports completion. It emits one pixel per
// cycle to a VGA adapter. Every output is registered, so outputs seen after
// edge n reflect the state that was current before edge n.
module frame_draw_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic [7:0] obstacle_x,
    input  logic [6:0] obstacle_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       pos_update,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE, ERASE_P, ERASE_O, UPDATE, LATCH, DRAW_P, DRAW_O, DONE
    } state_t;

    state_t     state_reg;
    logic [5:0] cnt_reg;
    logic       valid_reg;
    logic [7:0] old_px_reg;
    logic [6:0] old_py_reg;
    logic [7:0] old_ox_reg;
    logic [6:0] old_oy_reg;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       in_range;
    logic [2:0] pix_colour;
    logic       pixel_state;
    state_t     after_sprite;

    // Pixel address for the sprite selected by the current state. Sums are one
    // bit wider than the screen coordinates so off-screen pixels are detected
    // instead of wrapping.
    always_comb begin
        pixel_state  = 1'b0;
        pix_colour   = 3'b000;
        after_sprite = IDLE;
        base_x       = old_ox_reg;
        base_y       = old_oy_reg;
        case (state_reg)
            ERASE_P: begin
                pixel_state  = 1'b1;
                base_x       = old_px_reg;
                base_y       = old_py_reg;
                after_sprite = ERASE_O;
            end
            ERASE_O: begin
                pixel_state  = 1'b1;
                after_sprite = UPDATE;
            end
            DRAW_P: begin
                pixel_state  = 1'b1;
                pix_colour   = 3'b100;
                base_x       = old_px_reg;
                base_y       = old_py_reg;
                after_sprite = DRAW_O;
            end
            DRAW_O: begin
                pixel_state  = 1'b1;
                pix_colour   = 3'b001;
                after_sprite = DONE;
            end
            default: begin
                pixel_state = 1'b0;
            end
        endcase
        sum_x    = {1'b0, base_x} + {6'b000000, cnt_reg[2:0]};
        sum_y    = {1'b0, base_y} + {5'b00000, cnt_reg[5:3]};
        in_range = (sum_x <= 9'd159) && (sum_y <= 8'd119);
    end

    // Sequencer with registered outputs; strobes default low each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 6'd0;
            valid_reg  <= 1'b0;
            old_px_reg <= 8'd0;
            old_py_reg <= 7'd0;
            old_ox_reg <= 8'd0;
            old_oy_reg <= 7'd0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= 3'b000;
            plot       <= 1'b0;
            pos_update <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            plot       <= 1'b0;
            pos_update <= 1'b0;
            frame_done <= 1'b0;
            busy       <= (state_reg != IDLE);
            // A tick anywhere outside IDLE (including DONE) is dropped.
            if (frame_tick && (state_reg != IDLE)) begin
                overrun <= 1'b1;
            end
            if (pixel_state) begin
                plot    <= in_range;
                x       <= sum_x[7:0];
                y       <= sum_y[6:0];
                colour  <= pix_colour;
                cnt_reg <= cnt_reg + 6'd1;
                if (cnt_reg == 6'd63) begin
                    state_reg <= after_sprite;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (frame_tick && !game_over) begin
                            cnt_reg   <= 6'd0;
                            // Nothing has been drawn yet, so nothing to erase.
                            state_reg <= valid_reg ? ERASE_P : UPDATE;
                        end
                    end
                    UPDATE: begin
                        pos_update <= 1'b1;
                        state_reg  <= LATCH;
                    end
                    LATCH: begin
                        old_px_reg <= player_x;
                        old_py_reg <= player_y;
                        old_ox_reg <= obstacle_x;
                        old_oy_reg <= obstacle_y;
                        valid_reg  <= 1'b1;
                        cnt_reg    <= 6'd0;
                        state_reg  <= DRAW_P;
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        state_reg  <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Testbench for frame_draw_scheduler: a table of frame scenarios, hand
// sequences for game-over, overrun and mid-frame reset, and random frames.
// Expected outputs come from a cycle-index model of the frame timeline.
module tb_frame_draw_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] player_x = 8'd0;
    logic [6:0] player_y = 7'd0;
    logic [7:0] obstacle_x = 8'd0;
    logic [6:0] obstacle_y = 7'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       pos_update;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    frame_draw_scheduler dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
        .player_x(player_x), .player_y(player_y),
        .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .x(x), .y(y), .colour(colour), .plot(plot), .pos_update(pos_update),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic go;
        int   px, py, ox, oy;
        int   extra_tick;
        int   abort_at;
        int   exp_plots;
    } vec_t;

    vec_t tbl[9];
    int   checks = 0;
    int   failures = 0;

    // Reference state: whether a sprite set has been drawn, the drawn positions,
    // and the sticky overrun flag.
    int   m_valid = 0;
    int   m_px = 0, m_py = 0, m_ox = 0, m_oy = 0;
    int   m_overrun = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_garbage();
        player_x   = 8'($urandom_range(0, 255));
        player_y   = 7'($urandom_range(0, 127));
        obstacle_x = 8'($urandom_range(0, 255));
        obstacle_y = 7'($urandom_range(0, 127));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_colour"}, int'(colour), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_pos_update"}, int'(pos_update), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // One frame: tick at edge 0, then compare every cycle E1..E(len+1) with the
    // timeline. Position inputs hold the frame values only at the latch edge.
    task automatic run_frame(input int px, input int py, input int ox, input int oy,
                             input int extra, input int abort_at, input int exp_plots);
        int first, len, ee, plots, k, bx, by, c, pix, ex, ey, eplot;
        first = (m_valid == 0);
        len   = first ? 131 : 259;
        plots = 0;
        player_x = 8'(px); player_y = 7'(py); obstacle_x = 8'(ox); obstacle_y = 7'(oy);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        drive_garbage();
        for (int e = 1; e <= len + 1; e++) begin
            ee = first ? e + 128 : e;
            if (ee == 130) begin
                player_x = 8'(px); player_y = 7'(py); obstacle_x = 8'(ox); obstacle_y = 7'(oy);
            end
            if (e == extra) frame_tick = 1'b1;
            if (e == abort_at) reset = 1'b1;
            step();
            frame_tick = 1'b0;
            drive_garbage();
            if (e == abort_at) begin
                reset = 1'b0;
                check_reset_outputs("abort");
                m_valid = 0; m_overrun = 0;
                m_px = 0; m_py = 0; m_ox = 0; m_oy = 0;
                return;
            end
            if (e == extra) m_overrun = 1;
            pix = 1; k = 0; bx = 0; by = 0; c = 0;
            if (ee >= 1 && ee <= 64) begin
                k = ee - 1; bx = m_px; by = m_py; c = 0;
            end else if (ee >= 65 && ee <= 128) begin
                k = ee - 65; bx = m_ox; by = m_oy; c = 0;
            end else if (ee >= 131 && ee <= 194) begin
                k = ee - 131; bx = px; by = py; c = 4;
            end else if (ee >= 195 && ee <= 258) begin
                k = ee - 195; bx = ox; by = oy; c = 1;
            end else begin
                pix = 0;
            end
            ex = bx + (k % 8);
            ey = by + (k / 8);
            eplot = (pix != 0) && (ex < 160) && (ey < 120);
            chk("busy", int'(busy), (e <= len) ? 1 : 0);
            chk("plot", int'(plot), eplot);
            chk("pos_update", int'(pos_update), (ee == 129) ? 1 : 0);
            chk("frame_done", int'(frame_done), (ee == 259) ? 1 : 0);
            chk("overrun", int'(overrun), m_overrun);
            if (eplot != 0) begin
                chk("x", int'(x), ex);
                chk("y", int'(y), ey);
                chk("colour", int'(colour), c);
            end
            if (plot) plots++;
            if (ee == 130) begin
                m_px = px; m_py = py; m_ox = ox; m_oy = oy; m_valid = 1;
            end
        end
        if (exp_plots >= 0) chk("plot_total", plots, exp_plots);
    endtask

    // Tick while game_over is high: the block must stay idle.
    task automatic run_game_over();
        game_over  = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("go_busy", int'(busy), 0);
            chk("go_plot", int'(plot), 0);
            chk("go_pos_update", int'(pos_update), 0);
            chk("go_frame_done", int'(frame_done), 0);
        end
        game_over = 1'b0;
    endtask

    initial begin
        //           go    px   py   ox   oy  extra abort plots
        tbl[0] = '{1'b0,  20,  60, 150, 111,    0,   0,  128};
        tbl[1] = '{1'b0,  20,  58, 150, 111,    0,   0,  256};
        tbl[2] = '{1'b0,  20,  58, 156, 116,    0,   0,  208};
        tbl[3] = '{1'b0,  20,  58, 156, 116,  100,   0,  160};
        tbl[4] = '{1'b0,  40,  40,  80,  80,    0,  70,   -1};
        tbl[5] = '{1'b0,  30,  10,   0,   0,    0,   0,  128};
        tbl[6] = '{1'b1,   0,   0,   0,   0,    0,   0,   -1};
        tbl[7] = '{1'b0, 159, 119,   0,   0,    0,   0,  193};
        tbl[8] = '{1'b0, 159, 119,   0,   0,  259,   0,  130};

        reset = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check_reset_outputs("idle");

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].go) run_game_over();
            else run_frame(tbl[i].px, tbl[i].py, tbl[i].ox, tbl[i].oy,
                           tbl[i].extra_tick, tbl[i].abort_at, tbl[i].exp_plots);
        end

        for (int r = 0; r < 8; r++) begin
            int extra;
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 131)) : 0;
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            end
            run_frame(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 255)), int'($urandom_range(100, 127)),
                      extra, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
